// File: rtl/free_list_ckpt_pkg.sv
// Shared sizing for rename-stage register bookkeeping.
// Rename, the free lists and the ROB all take their index widths from here.
package free_list_ckpt_pkg;
    localparam int NUM_PRF      = 64;
    localparam int NUM_RSVD     = 32;
    localparam int RENAME_WIDTH = 4;
    localparam int COMMIT_WIDTH = 4;
    localparam int NUM_CKPT     = 4;

    localparam int PRF_INDEX_SIZE = $clog2(NUM_PRF);
    localparam int CKPT_ID_SIZE   = $clog2(NUM_CKPT);
    localparam int FREE_CNT_SIZE  = $clog2(NUM_PRF + 1);

    typedef logic [PRF_INDEX_SIZE-1:0] prf_idx_t;
endpackage

// File: rtl/prf_pick_n.sv
// Combinational picker: the N lowest clear bits of a busy vector, lowest first,
// plus how many were found. Shared by the integer and FP free lists.
module prf_pick_n #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic [WIDTH-1:0]        busy,
    output logic [N-1:0][IDX_W-1:0] idx,
    output logic [CNT_W-1:0]        found
);

    always_comb begin
        logic [CNT_W-1:0] hits;
        idx  = '0;
        hits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!busy[i] && hits < CNT_W'(N)) begin
                for (int k = 0; k < N; k++) begin
                    if (hits == CNT_W'(k)) begin
                        idx[k] = IDX_W'(i);
                    end
                end
                hits = hits + CNT_W'(1);
            end
        end
        found = hits;
    end

endmodule

// File: rtl/free_list_ckpt.sv
// Physical-register free list with a circular queue of branch checkpoints.
// Retires are applied to every snapshot so a recovery never resurrects a freed register.
module free_list_ckpt
    import free_list_ckpt_pkg::*;
#(
    parameter int NUM_PRF      = free_list_ckpt_pkg::NUM_PRF,
    parameter int NUM_RSVD     = free_list_ckpt_pkg::NUM_RSVD,
    parameter int RENAME_WIDTH = free_list_ckpt_pkg::RENAME_WIDTH,
    parameter int COMMIT_WIDTH = free_list_ckpt_pkg::COMMIT_WIDTH,
    parameter int NUM_CKPT     = free_list_ckpt_pkg::NUM_CKPT,
    localparam int IDX_W  = $clog2(NUM_PRF),
    localparam int CKPT_W = $clog2(NUM_CKPT),
    localparam int CNT_W  = $clog2(NUM_PRF + 1)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  stall,
    input  logic [RENAME_WIDTH-1:0]               prf_req,
    output logic [RENAME_WIDTH-1:0][IDX_W-1:0]    prf_out,
    output logic                                  allocatable,
    input  logic [COMMIT_WIDTH-1:0]               prf_retire_valid,
    input  logic [COMMIT_WIDTH-1:0][IDX_W-1:0]    prf_retire,
    input  logic                                  ckpt_save,
    output logic [CKPT_W-1:0]                     ckpt_id,
    output logic                                  ckpt_full,
    input  logic                                  ckpt_release,
    input  logic                                  recover,
    input  logic [CKPT_W-1:0]                     recover_id,
    output logic [CNT_W-1:0]                      free_num
);

    localparam int REQ_W = $clog2(RENAME_WIDTH + 1);
    localparam int PTR_W = CKPT_W + 1;
    localparam logic [NUM_PRF-1:0] RSVD_MASK = {NUM_PRF{1'b1}} >> (NUM_PRF - NUM_RSVD);

    logic [NUM_PRF-1:0] fl;
    logic [NUM_PRF-1:0] snap [NUM_CKPT];
    logic [CNT_W-1:0]   snap_cnt [NUM_CKPT];
    logic [PTR_W-1:0]   ckpt_head;
    logic [PTR_W-1:0]   ckpt_tail;

    logic [RENAME_WIDTH-1:0][IDX_W-1:0] pick_idx;
    logic [REQ_W-1:0]   pick_found;
    logic [REQ_W-1:0]   req_count;
    logic [NUM_PRF-1:0] grant_mask;
    logic [NUM_PRF-1:0] retire_mask;
    logic [NUM_PRF-1:0] fl_next;
    logic [CNT_W-1:0]   grant_count;
    logic [CNT_W-1:0]   ret_count;
    logic [CNT_W-1:0]   free_num_next;
    logic               save_take;
    logic               release_take;
    logic               ckpt_empty;
    logic [PTR_W-1:0]   head_next;
    logic [PTR_W-1:0]   tail_recover;
    logic [PTR_W-1:0]   live_cnt;
    logic [CKPT_W-1:0]  rec_off;

    prf_pick_n #(
        .WIDTH (NUM_PRF),
        .N     (RENAME_WIDTH)
    ) u_pick (
        .busy  (fl),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // The picker count also guards the grant if free_num ever disagrees with fl.
    assign req_count   = REQ_W'($countones(prf_req));
    assign allocatable = (CNT_W'(req_count) <= free_num) && (req_count <= pick_found)
                         && !stall && !recover;
    assign grant_count = allocatable ? CNT_W'(req_count) : '0;
    assign ret_count   = CNT_W'($countones(prf_retire_valid));

    always_comb begin
        logic [REQ_W-1:0] slot;
        prf_out    = '0;
        grant_mask = '0;
        slot       = '0;
        if (allocatable) begin
            for (int s = 0; s < RENAME_WIDTH; s++) begin
                if (prf_req[s]) begin
                    for (int k = 0; k < RENAME_WIDTH; k++) begin
                        if (slot == REQ_W'(k)) begin
                            prf_out[s]              = pick_idx[k];
                            grant_mask[pick_idx[k]] = 1'b1;
                        end
                    end
                    slot = slot + REQ_W'(1);
                end
            end
        end
    end

    always_comb begin
        retire_mask = '0;
        for (int c = 0; c < COMMIT_WIDTH; c++) begin
            if (prf_retire_valid[c]) begin
                retire_mask[prf_retire[c]] = 1'b1;
            end
        end
    end

    assign fl_next       = (fl | grant_mask) & ~retire_mask;
    assign free_num_next = free_num - grant_count + ret_count;

    assign ckpt_empty   = (ckpt_head == ckpt_tail);
    assign ckpt_full    = (ckpt_head[CKPT_W-1:0] == ckpt_tail[CKPT_W-1:0])
                          && (ckpt_head[CKPT_W] != ckpt_tail[CKPT_W]);
    assign ckpt_id      = ckpt_tail[CKPT_W-1:0];
    assign save_take    = ckpt_save && allocatable && !ckpt_full;
    assign release_take = ckpt_release && !ckpt_empty;
    assign head_next    = ckpt_head + PTR_W'(release_take);

    // A recovered slot below the head index sits in the next lap of the queue.
    assign tail_recover = {(recover_id >= head_next[CKPT_W-1:0]) ? head_next[CKPT_W]
                                                                 : ~head_next[CKPT_W],
                           recover_id};

    always_ff @(posedge clock) begin
        if (reset) begin
            fl        <= RSVD_MASK;
            free_num  <= CNT_W'(NUM_PRF - NUM_RSVD);
            ckpt_head <= '0;
            ckpt_tail <= '0;
        end else begin
            if (recover) begin
                fl        <= snap[recover_id] & ~retire_mask;
                free_num  <= snap_cnt[recover_id] + ret_count;
                ckpt_tail <= tail_recover;
            end else begin
                fl       <= fl_next;
                free_num <= free_num_next;
                if (save_take) begin
                    ckpt_tail <= ckpt_tail + PTR_W'(1);
                end
            end
            ckpt_head <= head_next;
        end
    end

    // Dead slots also absorb retires; they are overwritten before they are read again.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (save_take && (CKPT_W'(i) == ckpt_tail[CKPT_W-1:0])) begin
                snap[i]     <= fl_next;
                snap_cnt[i] <= free_num_next;
            end else begin
                snap[i]     <= snap[i] & ~retire_mask;
                snap_cnt[i] <= snap_cnt[i] + ret_count;
            end
        end
    end

    assign live_cnt = ckpt_tail - ckpt_head;
    assign rec_off  = recover_id - ckpt_head[CKPT_W-1:0];

    assert property (@(posedge clock) disable iff (reset)
        ckpt_save |-> (allocatable && !ckpt_full));
    assert property (@(posedge clock) disable iff (reset)
        ckpt_release |-> !ckpt_empty);
    assert property (@(posedge clock) disable iff (reset)
        recover |-> ({1'b0, rec_off} < live_cnt));
    assert property (@(posedge clock) disable iff (reset)
        (recover && ckpt_release) |-> (recover_id != ckpt_head[CKPT_W-1:0]));

    for (genvar c = 0; c < COMMIT_WIDTH; c++) begin : g_retire_chk
        assert property (@(posedge clock) disable iff (reset)
            prf_retire_valid[c] |-> fl[prf_retire[c]]);
    end

endmodule

// File: doc/free_list_ckpt.md
Name: free_list_ckpt

Overview:
Parametrised physical-register free list for the rename stage, with integrated branch checkpoints.
- Allocates up to RENAME_WIDTH physical registers per cycle and frees up to COMMIT_WIDTH per cycle.
- Keeps a circular queue of NUM_CKPT free-list snapshots, so a mispredict restores state in one cycle without the rename stage supplying a vector.
- Retires are applied to every live snapshot, so registers freed after a checkpoint stay free after recovery.

Parameters:
NUM_PRF, 64, number of physical registers
NUM_RSVD, 32, registers 0..NUM_RSVD-1 busy at reset (initial architectural mapping)
RENAME_WIDTH, 4, allocation requests per cycle
COMMIT_WIDTH, 4, retire frees per cycle
NUM_CKPT, 4, snapshot slots (power of two)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  1  rename stall; blocks allocation and checkpoint save
prf_req  in  RENAME_WIDTH  per-slot allocation request
prf_out  out  RENAME_WIDTH x clog2(NUM_PRF)  allocated index per requesting slot
allocatable  out  1  whole request group can be granted this cycle
prf_retire_valid  in  COMMIT_WIDTH  per-slot free valid
prf_retire  in  COMMIT_WIDTH x clog2(NUM_PRF)  index to free
ckpt_save  in  1  take a snapshot after this cycle's allocations
ckpt_id  out  clog2(NUM_CKPT)  slot the snapshot will occupy (tail)
ckpt_full  out  1  all NUM_CKPT slots live
ckpt_release  in  1  free the oldest (head) slot, used when its branch commits
recover  in  1  mispredict; restore snapshot recover_id
recover_id  in  clog2(NUM_CKPT)  slot to restore
free_num  out  clog2(NUM_PRF+1)  registered count of free registers

Behaviour:
- State:
  - free vector fl (1 = busy) and free_num counter.
  - Snapshot arrays snap[NUM_CKPT] with snap_cnt.
  - Queue pointers ckpt_head and ckpt_tail (clog2(NUM_CKPT)+1 bits, MSB = wrap).
- Reset:
  - fl bits 0..NUM_RSVD-1 = 1, others 0; free_num = NUM_PRF-NUM_RSVD.
  - Queue empty: head = tail = 0, ckpt_full = 0, ckpt_id = 0.
  - prf_out and allocatable are combinational: all zero if prf_req = 0. The snap contents are don't-care.
- Allocation (combinational, same cycle):
  - req_count = popcount(prf_req).
  - allocatable = (req_count <= free_num) and !stall and !recover.
  - Grant is all-or-nothing. The k-th set request bit (ascending slot order) gets the k-th lowest free index of registered fl.
  - Non-requesting slots and non-granted cycles drive prf_out = 0.
  - allocatable=1 with req_count=0 is legal and changes no state.
- Retire:
  - Frees take effect next cycle. They are not visible to same-cycle allocation (no bypass).
  - Each retire clears its bit in fl and in every live snapshot.
  - free_num += number of valid retires, and each live snap_cnt is increased by the same amount.
  - Retire is applied during stall and during recover. On recover it is applied on top of the restored snapshot.
  - Retiring a register that is already free is illegal (assertion); behaviour is unspecified.
- Next fl:
  - fl_next = (fl with granted bits set) with retired bits cleared.
  - free_num_next = free_num - granted + retired. It never exceeds NUM_PRF.
- Checkpoint save:
  - Taken when ckpt_save && allocatable && !ckpt_full.
  - snap[tail] = fl with this cycle's grants set and this cycle's retires cleared; snap_cnt matches; tail++.
  - ckpt_save while ckpt_full, stalled, or not allocatable is ignored. The rename stage must not assert it then (assertion).
- Release: ckpt_release with a non-empty queue advances head. On an empty queue it is ignored (assertion).
- Recover (highest priority over stall, save and allocate):
  - fl = snap[recover_id] with this cycle's retires cleared; free_num = its snap_cnt plus those retires.
  - tail = recover_id with the wrap bit recomputed relative to head. The recovered slot and all younger slots are discarded.
  - recover_id must be live (assertion).
  - release and recover in the same cycle: both apply; release first, which is only legal when recover_id != head.
- Queue flags: ckpt_full = (head and tail indices equal, wrap bits differ); ckpt_id = tail index.
- Reset mid-operation: reset wins over everything and returns to the reset state in one cycle.

Decomposition:
- Shared package: clog2-derived widths (PRF_INDEX_SIZE, CKPT_ID_SIZE, FREE_CNT_SIZE) and a prf_idx_t typedef. Rename, free list and ROB all use these.
- Sub-module prf_pick_n: a combinational priority picker returning the N lowest zero indices of a vector plus a found count. It is reused by the FP free list.

Test Plan:
- Reset then one cycle with prf_req=4'b1111 -> prf_out = {35,34,33,32} (slot3..slot0), allocatable=1; next cycle free_num=28.
- free_num=2, prf_req=4'b0111 -> allocatable=0, prf_out all 0, free_num stays 2. A same-cycle retire of 3 registers does not change this cycle's grant; next cycle free_num=5.
- Sparse request prf_req=4'b1010 after reset -> slot1=32, slot3=33, slot0 = slot2 = 0.
- Save checkpoint (ckpt_id=0) after allocating 32..35; allocate 36..43; retire 33; recover_id=0 -> fl busy = 0..32 and 34..35, free_num=29, queue empty, next alloc gives 33.
- Save 4 checkpoints -> ckpt_full=1 and a 5th save is ignored. Release head -> ckpt_full=0, ckpt_id wraps to 0. Recover to slot 2 -> slot 1 stays live and slots 2..3 are dropped.
- reset asserted the same cycle as recover, save and retire -> reset state exactly, free_num=32.
